cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, meaning max wait cycles in MEM phase before error.
REQ-002 Parameter CNT_W, default 16, meaning width of retired-instruction counter.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port run  input  1  free-run enable; level-sensitive.
REQ-006 Port step_req  input  1  single-step request; sampled in IDLE only.
REQ-007 Port halt_req  input  1  stop after current instruction completes.
REQ-008 Port clr_err  input  1  clears sticky error.
REQ-009 Port mem_r_en, mem_w_en, reg_w_en  input  1 each  decoded flags from control unit, valid from REGREAD onward.
REQ-010 Port mem_ready  input  1  data-memory completion handshake.
REQ-011 Port fetch, decode, regread, execute, access_mem, wb_resolve, writeback, update_pc  output  1 each  phase strobes.
REQ-012 Port phase  output  4  current state encoding.
REQ-013 Port busy  output  1  high in any state other than IDLE.
REQ-014 Port err  output  1  sticky memory-timeout error.
REQ-015 Port instr_retired  output  CNT_W  count of completed instructions.

Function
REQ-016 States: IDLE, FETCH, DECODE, REGREAD, EXECUTE, MEM, WBRES, WB, PCUPD; one state per cycle except MEM.
REQ-017 IDLE -> FETCH when (run or step_req) and not err; otherwise remain IDLE.
REQ-018 FETCH -> DECODE -> REGREAD -> EXECUTE unconditionally, one cycle each.
REQ-019 EXECUTE -> MEM if mem_r_en or mem_w_en, else EXECUTE -> WBRES (MEM skipped).
REQ-020 MEM: access_mem high every cycle in MEM; MEM -> WBRES in the cycle after mem_ready sampled high.
REQ-021 MEM wait counter starts at 0 on MEM entry and increments each cycle mem_ready is low; reaching MEM_TIMEOUT sets err and forces next state IDLE with no writeback, no PC update, no retirement.
REQ-022 WBRES -> WB -> PCUPD unconditionally; writeback strobe = reg_w_en while in WB, 0 otherwise.
REQ-023 PCUPD: instr_retired increments by 1, wrapping from 2^CNT_W-1 to 0.
REQ-024 PCUPD -> FETCH if run and not halt_req; else PCUPD -> IDLE.
REQ-025 A step_req-initiated instruction returns to IDLE after PCUPD unless run is high.
REQ-026 Each strobe is high exactly while in its state (fetch in FETCH, etc.), decoded combinationally from registered state; strobes are mutually exclusive.
REQ-027 halt_req asserted mid-instruction does not shorten it; the instruction completes through PCUPD.
REQ-028 clr_err clears err next cycle; if a timeout occurs in the same cycle, err stays set.
REQ-029 busy = (phase != IDLE).

Reset
REQ-030 On rst high at a clock edge: phase=IDLE, all strobes 0, err=0, instr_retired=0, wait counter=0, in every state including mid-MEM.
REQ-031 rst takes priority over run, step_req, clr_err and mem_ready.

Structure
REQ-032 State encoding enum (IDLE=0 .. PCUPD=8) and MEM_TIMEOUT default reside in shared package cpu_pkg, also used by cpu.
REQ-033 One sub-module: mem_wait_timer (clear, count-enable, timeout flag), instantiated once.

Verification
REQ-034 rst; run=1, mem flags 0, reg_w_en=1 -> phases 1,2,3,4,6,7,8 repeat; writeback high in WB; instr_retired=3 after 21 cycles.
REQ-035 mem_r_en=1, mem_ready high on 3rd MEM cycle -> access_mem high 3 cycles, WBRES on following cycle, instruction takes 10 cycles.
REQ-036 mem_w_en=1, mem_ready stuck 0, MEM_TIMEOUT=15 -> err=1 after 15 MEM cycles, phase=IDLE, instr_retired unchanged, run ignored until clr_err.
REQ-037 run=0, step_req pulsed once in IDLE -> exactly one instruction, instr_retired +1, return to IDLE, busy low.
REQ-038 run=1, halt_req pulsed in EXECUTE -> instruction completes PCUPD, then IDLE; rst asserted in MEM -> IDLE, all outputs 0 next cycle.
REQ-039 CNT_W=4, 16 instructions retired -> instr_retired wraps 15 -> 0.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: phase encoding and
// default limits, also consumed by the surrounding cpu logic.
package cpu_pkg;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;
    localparam int unsigned CNT_W_DEFAULT       = 16;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        REGREAD = 4'd3,
        EXECUTE = 4'd4,
        MEM     = 4'd5,
        WBRES   = 4'd6,
        WB      = 4'd7,
        PCUPD   = 4'd8
    } state_t;

    function automatic logic needs_mem(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the control unit and the sequencer.
// The sequencer connects through the slave modport.
interface cpu_sequencer_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             run;
    logic             step_req;
    logic             halt_req;
    logic             clr_err;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             reg_w_en;
    logic             mem_ready;

    logic             fetch;
    logic             decode;
    logic             regread;
    logic             execute;
    logic             access_mem;
    logic             wb_resolve;
    logic             writeback;
    logic             update_pc;
    logic [3:0]       phase;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        output run, step_req, halt_req, clr_err,
        output mem_r_en, mem_w_en, reg_w_en, mem_ready,
        input  fetch, decode, regread, execute, access_mem,
        input  wb_resolve, writeback, update_pc,
        input  phase, busy, err, instr_retired
    );

    modport slave (
        input  run, step_req, halt_req, clr_err,
        input  mem_r_en, mem_w_en, reg_w_en, mem_ready,
        output fetch, decode, regread, execute, access_mem,
        output wb_resolve, writeback, update_pc,
        output phase, busy, err, instr_retired
    );

endinterface

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Counts stalled MEM cycles; flags the cycle whose stall would reach LIMIT.
// Held at zero whenever clear is asserted (outside the MEM phase).
module mem_wait_timer
    import cpu_pkg::*;
#(
    parameter int unsigned LIMIT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en && !timeout) begin
            count <= count + 1'b1;
        end
    end

    // Combinational so the state machine can leave MEM on the same edge
    // that the count would reach LIMIT.
    assign timeout = count_en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction phase sequencer with memory-wait timeout,
// sticky error and retired-instruction counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    cpu_sequencer_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    logic             err_q;
    logic             err_nx;
    logic             halt_pend;
    logic             halt_pend_nx;
    logic [CNT_W-1:0] retired_q;
    logic             in_mem;
    logic             timeout;

    logic s_fetch, s_decode, s_regread, s_execute;
    logic s_access_mem, s_wb_resolve, s_writeback, s_update_pc;

    assign in_mem = (state == MEM);

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!in_mem),
        .count_en (in_mem && !bus.mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            err_q     <= 1'b0;
            halt_pend <= 1'b0;
            retired_q <= '0;
        end else begin
            state     <= state_nx;
            err_q     <= err_nx;
            halt_pend <= halt_pend_nx;
            if (state == PCUPD) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        s_fetch      = 1'b0;
        s_decode     = 1'b0;
        s_regread    = 1'b0;
        s_execute    = 1'b0;
        s_access_mem = 1'b0;
        s_wb_resolve = 1'b0;
        s_writeback  = 1'b0;
        s_update_pc  = 1'b0;

        unique case (state)
            IDLE: begin
                if ((bus.run || bus.step_req) && !err_q) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                s_fetch  = 1'b1;
                state_nx = DECODE;
            end
            DECODE: begin
                s_decode = 1'b1;
                state_nx = REGREAD;
            end
            REGREAD: begin
                s_regread = 1'b1;
                state_nx  = EXECUTE;
            end
            EXECUTE: begin
                s_execute = 1'b1;
                state_nx  = needs_mem(bus.mem_r_en, bus.mem_w_en) ? MEM : WBRES;
            end
            MEM: begin
                s_access_mem = 1'b1;
                if (bus.mem_ready) begin
                    state_nx = WBRES;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            WBRES: begin
                s_wb_resolve = 1'b1;
                state_nx     = WB;
            end
            WB: begin
                s_writeback = bus.reg_w_en;
                state_nx    = PCUPD;
            end
            PCUPD: begin
                s_update_pc = 1'b1;
                state_nx    = (bus.run && !bus.halt_req && !halt_pend) ? FETCH : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A halt seen at any point of an instruction is held until PCUPD so a
    // one-cycle pulse still stops the free-run loop after completion.
    always_comb begin
        halt_pend_nx = halt_pend | bus.halt_req;
        if (state == IDLE || state == PCUPD || timeout) begin
            halt_pend_nx = 1'b0;
        end
    end

    // A timeout in the same cycle as clr_err wins so the error is not lost.
    always_comb begin
        err_nx = err_q;
        if (timeout) begin
            err_nx = 1'b1;
        end else if (bus.clr_err) begin
            err_nx = 1'b0;
        end
    end

    assign bus.fetch         = s_fetch;
    assign bus.decode        = s_decode;
    assign bus.regread       = s_regread;
    assign bus.execute       = s_execute;
    assign bus.access_mem    = s_access_mem;
    assign bus.wb_resolve    = s_wb_resolve;
    assign bus.writeback     = s_writeback;
    assign bus.update_pc     = s_update_pc;
    assign bus.phase         = state;
    assign bus.busy          = (state != IDLE);
    assign bus.err           = err_q;
    assign bus.instr_retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus a random
// instruction stream checked against an instruction-level phase model.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.CNT_W(16)) bus ();
    cpu_sequencer_if #(.CNT_W(4))  bus4 ();

    cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.run = 0;  bus.step_req = 0; bus.halt_req = 0; bus.clr_err = 0;
        bus.mem_r_en = 0; bus.mem_w_en = 0; bus.reg_w_en = 0; bus.mem_ready = 0;
        bus4.run = 0; bus4.step_req = 0; bus4.halt_req = 0; bus4.clr_err = 0;
        bus4.mem_r_en = 0; bus4.mem_w_en = 0; bus4.reg_w_en = 0; bus4.mem_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    function automatic logic [7:0] strobes();
        return {bus.update_pc, bus.writeback, bus.wb_resolve, bus.access_mem,
                bus.execute, bus.regread, bus.decode, bus.fetch};
    endfunction

    // Phase n (1..8) owns strobe n-1; writeback additionally needs reg_w_en.
    function automatic logic [7:0] expect_strobes(input int p, input logic regw);
        logic [7:0] v;
        v = '0;
        if (p >= 1 && p <= 8) v[p-1] = 1'b1;
        if (p == 7 && !regw) v[6] = 1'b0;
        return v;
    endfunction

    task automatic test_reset();
        clear_inputs();
        bus.run = 1; bus.step_req = 1; bus.clr_err = 1; bus.mem_ready = 1;
        rst = 1;
        tick();
        tick();
        checks++; if (bus.phase !== 4'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", bus.phase); end
        checks++; if (strobes() !== 8'h00) begin failures++; $display("FAIL reset_strobes got=%h exp=00", strobes()); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        checks++; if (bus.instr_retired !== 16'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", bus.instr_retired); end
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_free_run();
        int seq[7] = '{1, 2, 3, 4, 6, 7, 8};
        do_reset();
        bus.reg_w_en = 1;
        bus.run = 1;
        tick();
        for (int c = 0; c < 21; c++) begin
            checks++;
            if (bus.phase !== 4'(seq[c % 7])) begin
                failures++; $display("FAIL free_run_phase cyc=%0d got=%0d exp=%0d", c, bus.phase, seq[c % 7]);
            end
            checks++;
            if (strobes() !== expect_strobes(seq[c % 7], 1'b1)) begin
                failures++; $display("FAIL free_run_strobes cyc=%0d got=%h exp=%h", c, strobes(), expect_strobes(seq[c % 7], 1'b1));
            end
            tick();
        end
        checks++; if (bus.instr_retired !== 16'd3) begin failures++; $display("FAIL free_run_retired got=%0d exp=3", bus.instr_retired); end
    endtask

    task automatic test_mem_read();
        int cyc = 0;
        int mem_cyc = 0;
        int after_mem = -1;
        logic rdy_given = 0;
        do_reset();
        bus.mem_r_en = 1;
        bus.run = 1;
        tick();
        bus.run = 0;
        while (bus.phase != 4'd0 && cyc < 40) begin
            if (bus.access_mem) begin
                mem_cyc++;
                bus.mem_ready = (mem_cyc == 3);
            end else begin
                bus.mem_ready = 0;
            end
            rdy_given = bus.mem_ready;
            cyc++;
            tick();
            if (rdy_given) after_mem = int'(bus.phase);
        end
        bus.mem_ready = 0;
        checks++; if (cyc !== 10) begin failures++; $display("FAIL mem_read_cycles got=%0d exp=10", cyc); end
        checks++; if (mem_cyc !== 3) begin failures++; $display("FAIL mem_read_access got=%0d exp=3", mem_cyc); end
        checks++; if (after_mem !== 6) begin failures++; $display("FAIL mem_read_next_phase got=%0d exp=6", after_mem); end
        checks++; if (bus.instr_retired !== 16'd1) begin failures++; $display("FAIL mem_read_retired got=%0d exp=1", bus.instr_retired); end
    endtask

    task automatic test_timeout();
        int m;
        int n;
        logic late;
        // Ready arriving in the 15th MEM cycle is still in time.
        do_reset();
        bus.mem_w_en = 1;
        bus.run = 1;
        tick();
        bus.run = 0;
        m = 0; n = 0;
        while (bus.phase != 4'd0 && n < 40) begin
            if (bus.access_mem) m++;
            bus.mem_ready = bus.access_mem && (m == 15);
            n++;
            tick();
        end
        bus.mem_ready = 0;
        checks++; if (m !== 15) begin failures++; $display("FAIL late_ready_mem_cycles got=%0d exp=15", m); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL late_ready_err got=%b exp=0", bus.err); end
        checks++; if (bus.instr_retired !== 16'd1) begin failures++; $display("FAIL late_ready_retired got=%0d exp=1", bus.instr_retired); end

        // Ready never comes: error after 15 MEM cycles, no completion.
        do_reset();
        bus.mem_w_en = 1;
        bus.reg_w_en = 1;
        bus.run = 1;
        tick();
        m = 0; n = 0; late = 0;
        while (bus.phase != 4'd0 && n < 40) begin
            if (bus.access_mem) m++;
            late |= bus.wb_resolve | bus.writeback | bus.update_pc;
            n++;
            tick();
        end
        checks++; if (m !== 15) begin failures++; $display("FAIL timeout_mem_cycles got=%0d exp=15", m); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", bus.err); end
        checks++; if (bus.phase !== 4'd0) begin failures++; $display("FAIL timeout_phase got=%0d exp=0", bus.phase); end
        checks++; if (bus.instr_retired !== 16'd0) begin failures++; $display("FAIL timeout_retired got=%0d exp=0", bus.instr_retired); end
        checks++; if (late !== 1'b0) begin failures++; $display("FAIL timeout_late_strobe got=%b exp=0", late); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.phase !== 4'd0) begin failures++; $display("FAIL timeout_run_ignored got=%0d exp=0", bus.phase); end
        end
        bus.clr_err = 1;
        tick();
        bus.clr_err = 0;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL clr_err got=%b exp=0", bus.err); end
        tick();
        checks++; if (bus.phase !== 4'd1) begin failures++; $display("FAIL restart_after_clr got=%0d exp=1", bus.phase); end

        // clr_err held through a timeout: the timeout wins.
        do_reset();
        bus.mem_r_en = 1;
        bus.run = 1;
        bus.clr_err = 1;
        tick();
        n = 0;
        while (bus.phase != 4'd0 && n < 40) begin n++; tick(); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL timeout_vs_clr got=%b exp=1", bus.err); end
        bus.clr_err = 0;
    endtask

    task automatic test_step();
        int cyc = 0;
        do_reset();
        bus.reg_w_en = 1;
        bus.step_req = 1;
        tick();
        bus.step_req = 0;
        while (bus.phase != 4'd0 && cyc < 30) begin cyc++; tick(); end
        checks++; if (cyc !== 7) begin failures++; $display("FAIL step_cycles got=%0d exp=7", cyc); end
        checks++; if (bus.instr_retired !== 16'd1) begin failures++; $display("FAIL step_retired got=%0d exp=1", bus.instr_retired); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL step_busy got=%b exp=0", bus.busy); end
        tick(); tick(); tick();
        checks++; if (bus.phase !== 4'd0) begin failures++; $display("FAIL step_stays_idle got=%0d exp=0", bus.phase); end
    endtask

    task automatic test_halt_and_reset();
        int n;
        int m;
        do_reset();
        bus.reg_w_en = 1;
        bus.run = 1;
        tick();
        n = 0;
        while (bus.phase != 4'd4 && n < 20) begin n++; tick(); end
        bus.halt_req = 1;
        tick();
        bus.halt_req = 0;
        n = 0;
        while (bus.phase != 4'd8 && n < 20) begin n++; tick(); end
        checks++; if (n !== 2) begin failures++; $display("FAIL halt_reaches_pcupd got=%0d exp=2", n); end
        tick();
        checks++; if (bus.phase !== 4'd0) begin failures++; $display("FAIL halt_idle got=%0d exp=0", bus.phase); end
        checks++; if (bus.instr_retired !== 16'd1) begin failures++; $display("FAIL halt_retired got=%0d exp=1", bus.instr_retired); end
        tick();
        checks++; if (bus.phase !== 4'd1) begin failures++; $display("FAIL halt_rerun got=%0d exp=1", bus.phase); end

        // Reset in the middle of a memory wait.
        bus.mem_r_en = 1;
        n = 0;
        while (bus.phase != 4'd5 && n < 20) begin n++; tick(); end
        tick(); tick();
        rst = 1;
        tick();
        checks++; if (bus.phase !== 4'd0) begin failures++; $display("FAIL mid_mem_rst_phase got=%0d exp=0", bus.phase); end
        checks++; if (strobes() !== 8'h00) begin failures++; $display("FAIL mid_mem_rst_strobes got=%h exp=00", strobes()); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_mem_rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.instr_retired !== 16'd0) begin failures++; $display("FAIL mid_mem_rst_retired got=%0d exp=0", bus.instr_retired); end
        rst = 0;
        tick();
        m = 0; n = 0;
        while (bus.phase != 4'd0 && n < 40) begin
            if (bus.access_mem) m++;
            n++;
            tick();
        end
        checks++; if (m !== 15) begin failures++; $display("FAIL wait_counter_cleared got=%0d exp=15", m); end
    endtask

    task automatic test_random();
        int exp_q[$];
        int retired_mdl = 0;
        int lat;
        int mem_idx;
        logic mem, regw, halt;
        do_reset();
        bus.run = 1;
        tick();
        for (int i = 0; i < 30; i++) begin
            mem  = ($urandom % 2) == 1;
            regw = ($urandom % 2) == 1;
            halt = ($urandom_range(0, 4) == 0);
            lat  = $urandom_range(0, 10);
            bus.mem_r_en = 0; bus.mem_w_en = 0;
            if (mem) begin
                if (($urandom % 2) == 1) bus.mem_r_en = 1; else bus.mem_w_en = 1;
            end
            bus.reg_w_en = regw;
            exp_q = '{1, 2, 3, 4};
            if (mem) for (int k = 0; k <= lat; k++) exp_q.push_back(5);
            exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(8);
            if (halt) exp_q.push_back(0);
            mem_idx = 0;
            foreach (exp_q[j]) begin
                checks++;
                if (bus.phase !== 4'(exp_q[j])) begin
                    failures++; $display("FAIL rand_phase instr=%0d step=%0d got=%0d exp=%0d", i, j, bus.phase, exp_q[j]);
                end
                checks++;
                if (strobes() !== expect_strobes(exp_q[j], regw)) begin
                    failures++; $display("FAIL rand_strobes instr=%0d step=%0d got=%h exp=%h", i, j, strobes(), expect_strobes(exp_q[j], regw));
                end
                bus.mem_ready = (exp_q[j] == 5) && (mem_idx == lat);
                if (exp_q[j] == 5) mem_idx++;
                bus.halt_req = (exp_q[j] == 4) && halt;
                tick();
            end
            bus.mem_ready = 0;
            bus.halt_req = 0;
            retired_mdl++;
            checks++;
            if (bus.instr_retired !== 16'(retired_mdl)) begin
                failures++; $display("FAIL rand_retired instr=%0d got=%0d exp=%0d", i, bus.instr_retired, retired_mdl);
            end
        end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rand_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_wrap();
        int mdl = 0;
        do_reset();
        bus4.run = 1;
        tick();
        for (int i = 0; i < 16; i++) begin
            repeat (7) tick();
            mdl = (mdl + 1) % 16;
            checks++;
            if (bus4.instr_retired !== 4'(mdl)) begin
                failures++; $display("FAIL wrap_retired instr=%0d got=%0d exp=%0d", i, bus4.instr_retired, mdl);
            end
        end
        bus4.run = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_free_run();
        test_mem_read();
        test_timeout();
        test_step();
        test_halt_and_reset();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
